// File: rtl/wb_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_arbiter_if : register-file write-back sources, write port and status     |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
interface wb_arbiter_if #(
  parameter int DEPTH = 4,
  parameter int N     = 64
);
  logic                     p_we;
  logic [4:0]               p_wa;
  logic [N-1:0]             p_wd;
  logic                     s_valid;
  logic                     s_ready;
  logic [4:0]               s_wa;
  logic [N-1:0]             s_wd;
  logic                     we3;
  logic [4:0]               wa3;
  logic [N-1:0]             wd3;
  logic [31:0]              pending;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport slave (
    input  p_we, p_wa, p_wd, s_valid, s_wa, s_wd,
    output s_ready, we3, wa3, wd3, pending, fifo_count
  );

  modport master (
    output p_we, p_wa, p_wd, s_valid, s_wa, s_wd,
    input  s_ready, we3, wa3, wd3, pending, fifo_count
  );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_arbiter : primary/secondary write-back merge with squashing FIFO.        |
// | Optional same-cycle secondary bypass when WB_BYPASS_EN is defined.          |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int N     = 64
) (
  input  logic           clk,
  input  logic           reset_n,
  wb_arbiter_if.slave    bus
);

  localparam int         PW  = $clog2(DEPTH);
  localparam int         CW  = PW + 1;
  localparam logic [4:0] XZR = 5'd31;

  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q,  count_d;
  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]     wa_q [DEPTH];
  logic [4:0]     wa_d [DEPTH];
  logic [N-1:0]   wd_q [DEPTH];
  logic [N-1:0]   wd_d [DEPTH];

  logic           p_win;
  logic           s_ready;
  logic           accept;
  logic           head_occ;
  logic           head_live;
  logic           bypass;
  logic           pop;
  logic           push;
  logic           we3;
  logic [4:0]     wa3;
  logic [N-1:0]   wd3;
  logic [31:0]    pending;

  // Reset gates the outputs combinationally so they are quiet while reset_n is low.
  assign p_win     = reset_n && bus.p_we && (bus.p_wa != XZR);
  assign s_ready   = reset_n && (count_q < CW'(DEPTH));
  assign accept    = bus.s_valid && s_ready;
  assign head_occ  = (count_q != '0);
  assign head_live = head_occ && live_q[rd_ptr_q];

`ifdef WB_BYPASS_EN
  assign bypass = accept && (count_q == '0) && !p_win && (bus.s_wa != XZR);
`else
  assign bypass = 1'b0;
`endif

  // A squashed head drains even while the primary owns the port.
  assign pop  = head_occ && (!head_live || !p_win);
  assign push = accept && (bus.s_wa != XZR) && !bypass;

  always_comb begin
    we3 = 1'b0;
    wa3 = '0;
    wd3 = '0;
    if (p_win) begin
      we3 = 1'b1;
      wa3 = bus.p_wa;
      wd3 = bus.p_wd;
    end else if (head_live) begin
      we3 = 1'b1;
      wa3 = wa_q[rd_ptr_q];
      wd3 = wd_q[rd_ptr_q];
    end else if (bypass) begin
      we3 = 1'b1;
      wa3 = bus.s_wa;
      wd3 = bus.s_wd;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) begin
        pending[wa_q[i]] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    live_d   = live_q;
    wa_d     = wa_q;
    wd_d     = wd_q;

    // The primary write is program-newer than anything already queued to the same register.
    for (int i = 0; i < DEPTH; i++) begin
      if (p_win && (wa_q[i] == bus.p_wa)) begin
        live_d[i] = 1'b0;
      end
    end

    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PW'(1);
    end

    // Applied after the squash so a same-cycle request to the same register survives.
    if (push) begin
      live_d[wr_ptr_q] = 1'b1;
      wa_d[wr_ptr_q]   = bus.s_wa;
      wd_d[wr_ptr_q]   = bus.s_wd;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      live_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        wa_q[i] <= '0;
        wd_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      live_q   <= live_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.we3        = we3;
  assign bus.wa3        = wa3;
  assign bus.wd3        = wd3;
  assign bus.pending    = pending;
  assign bus.fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wb_arbiter : directed and randomized checks of wb_arbiter against a      |
// | queue-based model of the write-back rules. Revision: 1.0                    |
// +----------------------------------------------------------------------------+
module tb_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int N     = 64;

  typedef struct {
    logic [4:0]  wa;
    logic [63:0] wd;
    bit          sq;
  } ent_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   wrote_xzr;
  ent_t q[$];
  logic [63:0] dut_rf [32];

  wb_arbiter_if #(.DEPTH(DEPTH), .N(N)) bus ();

  wb_arbiter #(.DEPTH(DEPTH), .N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_in(input bit pwe, input logic [4:0] pwa, input logic [63:0] pwd,
                        input bit sv, input logic [4:0] swa, input logic [63:0] swd);
    bus.p_we    = pwe;
    bus.p_wa    = pwa;
    bus.p_wd    = pwd;
    bus.s_valid = sv;
    bus.s_wa    = swa;
    bus.s_wd    = swd;
  endtask

  // One clock: compare against the model at the falling edge, advance the model at the rising edge.
  task automatic tick(input string tag);
    bit          p_win, head_live, byp, acc, do_pop, do_push;
    logic        e_we, e_rdy;
    logic [4:0]  e_wa;
    logic [63:0] e_wd;
    logic [31:0] e_pend;
    int          e_cnt;
    @(negedge clk);
    p_win = 0; head_live = 0; byp = 0; acc = 0; do_pop = 0; do_push = 0;
    e_we = 0; e_wa = 0; e_wd = 0; e_pend = 0; e_rdy = 0; e_cnt = 0;
    if (reset_n) begin
      p_win     = bus.p_we && (bus.p_wa != 5'd31);
      e_cnt     = q.size();
      e_rdy     = (q.size() < DEPTH);
      acc       = bus.s_valid && e_rdy;
      head_live = (q.size() > 0) && !q[0].sq;
`ifdef WB_BYPASS_EN
      byp = acc && (q.size() == 0) && !p_win && (bus.s_wa != 5'd31);
`endif
      foreach (q[i]) if (!q[i].sq) e_pend[q[i].wa] = 1'b1;
      if (p_win) begin
        e_we = 1; e_wa = bus.p_wa; e_wd = bus.p_wd;
      end else if (head_live) begin
        e_we = 1; e_wa = q[0].wa; e_wd = q[0].wd;
      end else if (byp) begin
        e_we = 1; e_wa = bus.s_wa; e_wd = bus.s_wd;
      end
      do_pop  = (q.size() > 0) && (q[0].sq || !p_win);
      do_push = acc && (bus.s_wa != 5'd31) && !byp;
    end
    chk({tag, ".we3"},     bus.we3, e_we);
    chk({tag, ".wa3"},     bus.wa3, e_wa);
    chk({tag, ".wd3"},     bus.wd3, e_wd);
    chk({tag, ".s_ready"}, bus.s_ready, e_rdy);
    chk({tag, ".pending"}, bus.pending, e_pend);
    chk({tag, ".count"},   bus.fifo_count, e_cnt);
    if (bus.we3 === 1'b1) begin
      if (bus.wa3 == 5'd31) wrote_xzr++;
      dut_rf[bus.wa3] = bus.wd3;
    end
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (p_win) foreach (q[i]) if (q[i].wa == bus.p_wa) q[i].sq = 1;
      if (do_push) q.push_back('{wa: bus.s_wa, wd: bus.s_wd, sq: 0});
    end
    #1;
  endtask

  initial begin
    logic [63:0] d;
    int          r;
    bit          pwe;
    logic [4:0]  pwa, swa;
    checks = 0; errors = 0; wrote_xzr = 0;
    for (int i = 0; i < 32; i++) dut_rf[i] = '0;

    // Reset with an active primary request
    reset_n = 1'b0;
    set_in(1, 5'd5, 64'h55, 0, 5'd0, 64'h0);
    tick("rst0");
    tick("rst1");
    reset_n = 1'b1;
    set_in(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    tick("rst_rel");

    // Buffering under continuous primary traffic to X9
    for (int i = 1; i <= 4; i++) begin
      set_in(1, 5'd9, 64'h900 + 64'(i), 1, 5'(i), 64'h11 * 64'(i));
      tick("buf_push");
    end
    set_in(1, 5'd9, 64'h999, 0, 5'd0, 64'h0);
    #1;
    chk("buf_full_ready", bus.s_ready, 1'b0);
    chk("buf_full_count", bus.fifo_count, 4);
    chk("buf_full_pend",  bus.pending, 32'h1E);
    tick("buf_hold");
    for (int i = 1; i <= 4; i++) begin
      set_in(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
      #1;
      chk("buf_drain_wa", bus.wa3, 5'(i));
      chk("buf_drain_wd", bus.wd3, 64'h11 * 64'(i));
      tick("buf_drain");
    end

    // Squash of a queued write by a newer primary write
    set_in(1, 5'd9, 64'h1, 1, 5'd7, 64'hAA);
    tick("sq_queue");
    set_in(1, 5'd7, 64'hBB, 0, 5'd0, 64'h0);
    tick("sq_primary");
    set_in(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    #1;
    chk("sq_pend7", bus.pending[7], 1'b0);
    chk("sq_we3",   bus.we3, 1'b0);
    chk("sq_count", bus.fifo_count, 1);
    tick("sq_pop");
    chk("sq_empty", bus.fifo_count, 0);
    chk("sq_rf7",   dut_rf[7], 64'hBB);

    // XZR handling on both sources
    set_in(1, 5'd9, 64'h2, 1, 5'd31, 64'hDEAD);
    #1;
    chk("xzr_ready", bus.s_ready, 1'b1);
    tick("xzr_sec");
    chk("xzr_count", bus.fifo_count, 0);
    set_in(1, 5'd9, 64'h3, 1, 5'd2, 64'h2222);
    tick("xzr_q2");
    set_in(1, 5'd31, 64'hBAD, 0, 5'd0, 64'h0);
    #1;
    chk("xzr_head_we", bus.we3, 1'b1);
    chk("xzr_head_wa", bus.wa3, 5'd2);
    tick("xzr_pri");

    // Full FIFO with a simultaneous pop: no push that cycle
    for (int i = 0; i < 4; i++) begin
      set_in(1, 5'd9, 64'h4, 1, 5'(10 + i), 64'hF0 + 64'(i));
      tick("full_fill");
    end
    set_in(0, 5'd0, 64'h0, 1, 5'd14, 64'hF4);
    #1;
    chk("full_ready", bus.s_ready, 1'b0);
    chk("full_pop_wa", bus.wa3, 5'd10);
    tick("full_pop");
    set_in(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    #1;
    chk("full_after_count", bus.fifo_count, 3);
    chk("full_after_ready", bus.s_ready, 1'b1);
    for (int i = 0; i < 3; i++) tick("full_drain");

    // Secondary request into an empty FIFO
    set_in(0, 5'd0, 64'h0, 1, 5'd3, 64'h3C);
    #1;
`ifdef WB_BYPASS_EN
    chk("byp_we", bus.we3, 1'b1);
    chk("byp_wa", bus.wa3, 5'd3);
`else
    chk("byp_we", bus.we3, 1'b0);
`endif
    tick("byp_req");
    set_in(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
    #1;
`ifdef WB_BYPASS_EN
    chk("byp_count", bus.fifo_count, 0);
`else
    chk("byp_count", bus.fifo_count, 1);
    chk("byp_late_wa", bus.wa3, 5'd3);
    chk("byp_late_wd", bus.wd3, 64'h3C);
`endif
    tick("byp_next");

    // Randomized traffic over a narrow register range so squashes are frequent
    for (int c = 0; c < 400; c++) begin
      pwe = ($urandom_range(0, 99) < ((c < 200) ? 70 : 30));
      r   = $urandom_range(0, 8);
      pwa = (r == 8) ? 5'd31 : 5'(r);
      r   = $urandom_range(0, 8);
      swa = (r == 8) ? 5'd31 : 5'(r);
      d   = {$urandom, $urandom};
      set_in(pwe, pwa, d, 1'($urandom_range(0, 1)), swa, {$urandom, $urandom});
      if (c == 150) begin
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_we3",   bus.we3, 1'b0);
        chk("async_rst_ready", bus.s_ready, 1'b0);
        chk("async_rst_count", bus.fifo_count, 0);
        chk("async_rst_pend",  bus.pending, 32'h0);
        tick("rand_rst");
        reset_n = 1'b1;
      end else begin
        tick("rand");
      end
    end

    chk("xzr_never_written", wrote_xzr, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
